// File: rtl/window_dispatcher_pkg.sv
// Shared constants, helpers and FSM state type for the window dispatcher.
// The DEF_* values are the default geometry; the modules derive their own widths from their parameters.
package cnn_pr_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned win_idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_IF_WIDTH    = 34;
    localparam int unsigned DEF_BLOCK_WIDTH = 10;
    localparam int unsigned DEF_OVERLAP     = 2;
    localparam int unsigned DEF_NUM_LANE    = 4;
    localparam int unsigned DEF_FIFO_DEPTH  = 4;
    localparam int unsigned DEF_HELP_THRESH = 2;

    localparam int unsigned STRIDE    = DEF_BLOCK_WIDTH - DEF_OVERLAP;
    localparam int unsigned NUM_WIN   = (DEF_IF_WIDTH - DEF_OVERLAP) / STRIDE;
    localparam int unsigned WIN_IDX_W = win_idx_w(NUM_WIN);
    localparam int unsigned ENTRY_W   = 1 + WIN_IDX_W + DEF_BLOCK_WIDTH * DEF_DATA_WIDTH;
    localparam int unsigned CNT_W     = clog2(DEF_FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        IDLE,
        DISPATCH
    } state_t;

endpackage

// File: rtl/window_dispatcher_if.sv
// Row-input and lane-output handshake bundle of the window dispatcher.
interface window_dispatcher_if import cnn_pr_pkg::*; #(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned IF_WIDTH    = DEF_IF_WIDTH,
    parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH,
    parameter int unsigned OVERLAP     = DEF_OVERLAP,
    parameter int unsigned NUM_LANE    = DEF_NUM_LANE
);
    localparam int unsigned STRIDE_L  = BLOCK_WIDTH - OVERLAP;
    localparam int unsigned NUM_WIN_L = (IF_WIDTH - OVERLAP) / STRIDE_L;
    localparam int unsigned ENTRY_W_L = 1 + win_idx_w(NUM_WIN_L) + BLOCK_WIDTH * DATA_WIDTH;

    logic                            in_valid;
    logic                            in_ready;
    logic [IF_WIDTH*DATA_WIDTH-1:0]  in_data;
    logic [NUM_WIN_L-1:0]            in_mask;
    logic [NUM_LANE-1:0]             out_valid;
    logic [NUM_LANE-1:0]             out_ready;
    logic [NUM_LANE*ENTRY_W_L-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/window_dispatcher_lane_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output; en_i freezes all state.
module lane_fifo import cnn_pr_pkg::*; #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (32'(count_q) != DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (en_i) begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= ptr_next(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
endmodule

// File: rtl/window_dispatcher.sv
// Cuts a latched row into overlapping windows and dispatches valid ones, lowest index first,
// into per-lane FIFOs, diverting to the partner lane when the home lane runs ahead.
module window_dispatcher import cnn_pr_pkg::*; #(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned IF_WIDTH    = DEF_IF_WIDTH,
    parameter int unsigned BLOCK_WIDTH = DEF_BLOCK_WIDTH,
    parameter int unsigned OVERLAP     = DEF_OVERLAP,
    parameter int unsigned NUM_LANE    = DEF_NUM_LANE,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned HELP_THRESH = DEF_HELP_THRESH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 help_en,
    window_dispatcher_if.slave   bus,
    output logic                 row_done,
    output logic                 busy,
    output logic [15:0]          help_cnt
);
    localparam int unsigned STRIDE_L    = BLOCK_WIDTH - OVERLAP;
    localparam int unsigned NUM_WIN_L   = (IF_WIDTH - OVERLAP) / STRIDE_L;
    localparam int unsigned WIN_IDX_W_L = win_idx_w(NUM_WIN_L);
    localparam int unsigned WIN_W       = BLOCK_WIDTH * DATA_WIDTH;
    localparam int unsigned ENTRY_W_L   = 1 + WIN_IDX_W_L + WIN_W;
    localparam int unsigned ROW_W       = IF_WIDTH * DATA_WIDTH;
    localparam int unsigned CNT_W_L     = clog2(FIFO_DEPTH + 1);
    localparam int unsigned LANE_W      = (NUM_LANE > 1) ? clog2(NUM_LANE) : 1;

    state_t                  state_q;
    logic [ROW_W-1:0]        row_q;
    logic [NUM_WIN_L-1:0]    mask_q;
    logic                    row_done_q;
    logic [15:0]             help_cnt_q;

    logic [WIN_IDX_W_L-1:0]  win_idx;
    logic [LANE_W-1:0]       home, partner, tgt;
    logic                    helped, tgt_full;
    logic [WIN_W-1:0]        win_data;
    logic [ENTRY_W_L-1:0]    entry;
    logic [NUM_WIN_L-1:0]    mask_d;
    logic [NUM_LANE-1:0]     push, fifo_valid;
    logic [CNT_W_L-1:0]      lane_cnt  [NUM_LANE];
    logic [ENTRY_W_L-1:0]    lane_data [NUM_LANE];

    // Descending scan so the lowest set bit wins.
    always_comb begin
        win_idx = '0;
        for (int unsigned i = NUM_WIN_L; i > 0; i--) begin
            if (mask_q[i-1]) win_idx = WIN_IDX_W_L'(i - 1);
        end
    end

    always_comb begin
        home     = LANE_W'(32'(win_idx) % NUM_LANE);
        partner  = LANE_W'((32'(home) + NUM_LANE / 2) % NUM_LANE);
        helped   = help_en
                   && (32'(lane_cnt[home]) >= 32'(lane_cnt[partner]) + HELP_THRESH)
                   && (32'(lane_cnt[partner]) != FIFO_DEPTH);
        tgt      = helped ? partner : home;
        tgt_full = (32'(lane_cnt[tgt]) == FIFO_DEPTH);
        win_data = row_q[ROW_W - 1 - 32'(win_idx) * STRIDE_L * DATA_WIDTH -: WIN_W];
        entry    = {helped, win_idx, win_data};
        mask_d   = mask_q & ~(NUM_WIN_L'(1) << win_idx);
        for (int unsigned l = 0; l < NUM_LANE; l++) begin
            push[l] = clk_en && (state_q == DISPATCH) && !tgt_full && (tgt == LANE_W'(l));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            mask_q     <= '0;
            row_done_q <= 1'b0;
            help_cnt_q <= '0;
        end else if (clk_en) begin
            row_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        row_q  <= bus.in_data;
                        mask_q <= bus.in_mask;
                        if (bus.in_mask == '0) row_done_q <= 1'b1;
                        else                   state_q    <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (!tgt_full) begin
                        mask_q <= mask_d;
                        if (helped && (help_cnt_q != '1)) help_cnt_q <= help_cnt_q + 16'd1;
                        if (mask_d == '0) begin
                            row_done_q <= 1'b1;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
        lane_fifo #(
            .WIDTH (ENTRY_W_L),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .en_i    (clk_en),
            .push_i  (push[l]),
            .data_i  (entry),
            .pop_i   (bus.out_ready[l]),
            .data_o  (lane_data[l]),
            .valid_o (fifo_valid[l]),
            .count_o (lane_cnt[l])
        );
    end

    always_comb begin
        bus.out_data = '0;
        for (int unsigned l = 0; l < NUM_LANE; l++) begin
            bus.out_data[l*ENTRY_W_L +: ENTRY_W_L] = lane_data[l];
        end
    end

    assign bus.in_ready  = clk_en && (state_q == IDLE);
    assign bus.out_valid = clk_en ? fifo_valid : '0;
    assign row_done      = row_done_q;
    assign busy          = (state_q == DISPATCH);
    assign help_cnt      = help_cnt_q;
endmodule

// File: tb/tb_window_dispatcher.sv
// Directed bench: stimulus pushes expected lane entries into per-lane queues, a negedge monitor checks pops.
module tb_window_dispatcher;
    import cnn_pr_pkg::*;

    localparam int unsigned DW = 8, IFW = 34, BW = 10, OV = 2, NL = 4, FD = 4, HT = 2;
    localparam int unsigned WINW = BW * DW;
    localparam int unsigned EW   = 1 + 2 + WINW;

    logic        clk = 1'b0;
    logic        rst, clk_en, help_en, row_done, busy;
    logic [15:0] help_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [EW-1:0] expq [NL][$];

    window_dispatcher_if #(
        .DATA_WIDTH (DW), .IF_WIDTH (IFW), .BLOCK_WIDTH (BW), .OVERLAP (OV), .NUM_LANE (NL)
    ) bus ();

    window_dispatcher #(
        .DATA_WIDTH (DW), .IF_WIDTH (IFW), .BLOCK_WIDTH (BW), .OVERLAP (OV),
        .NUM_LANE (NL), .FIFO_DEPTH (FD), .HELP_THRESH (HT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .help_en  (help_en),
        .bus      (bus),
        .row_done (row_done),
        .busy     (busy),
        .help_cnt (help_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [IFW*DW-1:0] make_row(input logic [7:0] base);
        logic [IFW*DW-1:0] r;
        for (int c = 0; c < IFW; c++) r[(IFW-c)*DW-1 -: DW] = base + 8'(c);
        return r;
    endfunction

    // Window w holds columns 8w .. 8w+9 with the first column in the MSBs.
    function automatic logic [WINW-1:0] win_of(input logic [7:0] base, input int w);
        logic [WINW-1:0] v;
        for (int k = 0; k < BW; k++) v[(BW-k)*DW-1 -: DW] = base + 8'(w * 8 + k);
        return v;
    endfunction

    task automatic expect_entry(input int lane, input logic helped, input int idx, input logic [WINW-1:0] d);
        expq[lane].push_back({helped, 2'(idx), d});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int l = 0; l < NL; l++) begin
                if (bus.out_valid[l] && bus.out_ready[l]) begin
                    if (expq[l].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop lane%0d: got %0h expected nothing", l, bus.out_data[l*EW +: EW]);
                    end else begin
                        check($sformatf("lane%0d_entry", l), 128'(bus.out_data[l*EW +: EW]), 128'(expq[l].pop_front()));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [3:0] mask, input logic [7:0] base);
        int n;
        bus.in_data  = make_row(base);
        bus.in_mask  = mask;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic drain(input int cycles);
        bus.out_ready = '1;
        repeat (cycles) tick();
        for (int l = 0; l < NL; l++) check($sformatf("pending_lane%0d", l), expq[l].size(), 0);
    endtask

    initial begin
        rst           = 1'b1;
        clk_en        = 1'b1;
        help_en       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mask   = '0;
        bus.out_ready = '0;
        tick();
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 4'b0);
        check("rst_out_data", (bus.out_data != '0), 1'b0);
        check("rst_row_done", row_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_help_cnt", help_cnt, 16'd0);
        tick();
        rst = 1'b0;
        tick();

        // Full row, every window to its home lane.
        bus.out_ready = '1;
        expect_entry(0, 1'b0, 0, win_of(8'h00, 0));
        expect_entry(1, 1'b0, 1, 80'h08090A0B0C0D0E0F1011);
        expect_entry(2, 1'b0, 2, win_of(8'h00, 2));
        expect_entry(3, 1'b0, 3, win_of(8'h00, 3));
        send_row(4'hF, 8'h00);
        check("t1_busy", busy, 1'b1);
        check("t1_in_ready", bus.in_ready, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("t1_row_done_c%0d", k), row_done, (k == 4));
        end
        check("t1_help_cnt", help_cnt, 16'd0);
        drain(4);

        // Empty mask: immediate row_done, no dispatch.
        send_row(4'h0, 8'h40);
        check("t2_row_done", row_done, 1'b1);
        check("t2_busy", busy, 1'b0);
        check("t2_in_ready", bus.in_ready, 1'b1);
        tick();
        check("t2_row_done_clr", row_done, 1'b0);
        check("t2_busy_after", busy, 1'b0);

        // Helping: third row diverts from lane 0 to lane 2.
        bus.out_ready = '0;
        help_en       = 1'b1;
        expect_entry(0, 1'b0, 0, win_of(8'h10, 0));
        expect_entry(0, 1'b0, 0, win_of(8'h20, 0));
        expect_entry(2, 1'b1, 0, win_of(8'h30, 0));
        send_row(4'h1, 8'h10);
        send_row(4'h1, 8'h20);
        send_row(4'h1, 8'h30);
        wait_idle();
        check("t3_help_cnt", help_cnt, 16'd1);
        check("t3_out_valid", bus.out_valid, 4'b0101);
        drain(8);
        help_en = 1'b0;

        // Full home lane stalls until one pop frees a slot.
        bus.out_ready = '0;
        for (int r = 0; r < 5; r++) expect_entry(0, 1'b0, 0, win_of(8'(8'h50 + 8'h10 * r), 0));
        for (int r = 0; r < 4; r++) send_row(4'h1, 8'(8'h50 + 8'h10 * r));
        wait_idle();
        check("t4_full_valid", bus.out_valid, 4'b0001);
        send_row(4'h1, 8'h90);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t4_stall_busy_c%0d", k), busy, 1'b1);
            check($sformatf("t4_stall_in_ready_c%0d", k), bus.in_ready, 1'b0);
            tick();
        end
        bus.out_ready = 4'b0001;
        tick();
        bus.out_ready = '0;
        check("t4_row_done_early", row_done, 1'b0);
        check("t4_busy_pre_push", busy, 1'b1);
        tick();
        check("t4_row_done", row_done, 1'b1);
        check("t4_busy_done", busy, 1'b0);
        drain(8);

        // Reset with two windows still pending.
        bus.out_ready = '0;
        check("t5_help_cnt_pre", help_cnt, 16'd1);
        send_row(4'hF, 8'hA0);
        tick();
        tick();
        check("t5_busy_pre", busy, 1'b1);
        check("t5_valid_pre", bus.out_valid, 4'b0011);
        rst = 1'b1;
        #1;
        check("t5_out_valid", bus.out_valid, 4'b0);
        check("t5_in_ready", bus.in_ready, 1'b1);
        check("t5_help_cnt", help_cnt, 16'd0);
        check("t5_busy", busy, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        bus.out_ready = '1;
        repeat (8) tick();
        check("t5_no_stale", bus.out_valid, 4'b0);
        check("t5_busy_after", busy, 1'b0);

        // Clock-enable freeze in the middle of a row.
        bus.out_ready = '0;
        for (int w = 0; w < 4; w++) expect_entry(w, 1'b0, w, win_of(8'hC0, w));
        send_row(4'hF, 8'hC0);
        tick();
        check("t6_valid_w0", bus.out_valid, 4'b0001);
        clk_en = 1'b0;
        #1;
        check("t6_frz_in_ready", bus.in_ready, 1'b0);
        check("t6_frz_out_valid", bus.out_valid, 4'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("t6_frz_valid_c%0d", k), bus.out_valid, 4'b0);
            check($sformatf("t6_frz_busy_c%0d", k), busy, 1'b1);
        end
        clk_en = 1'b1;
        #1;
        check("t6_resume_valid", bus.out_valid, 4'b0001);
        tick();
        check("t6_next_window", bus.out_valid, 4'b0011);
        wait_idle();
        check("t6_all_valid", bus.out_valid, 4'b1111);
        drain(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
